// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode constants and sequencer state type shared by pc_sequencer and next_pc_calc
package riscv_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT_MEM, S_HALT} pc_seq_state_t;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC select (branch/jal pc+imm, jalr alu&~1, else pc+4) with misalign flag; in opcode/pc/imm/alu_result/branch_taken, out next_pc/misalign
module next_pc_calc import riscv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [6:0]      opcode,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            branch_taken,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);
  always_comb begin
    next_pc = (opcode == OP_JAL || (opcode == OP_BRANCH && branch_taken)) ? pc + imm :
              (opcode == OP_JALR) ? alu_result & ~XLEN'(1) : pc + XLEN'(4);
    misalign = |next_pc[1:0];
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/exec/commit PC controller; imem req/ack fetch, dmem_busy stall, branch/jal/jalr commit, halts on SYSTEM or misaligned target; PC_SEQ_PERF_CNT_EN adds cycle_cnt/instret_cnt
module pc_sequencer import riscv_pkg::*; #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            dmem_busy,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic            commit,
  output logic            halted,
  output logic            misaligned
`ifdef PC_SEQ_PERF_CNT_EN
  ,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
`endif
);
  pc_seq_state_t state, state_nxt;
  logic [XLEN-1:0] next_pc;
  logic misalign;
  logic ld_st;
  next_pc_calc #(.XLEN(XLEN)) u_next_pc (
    .opcode(instr[6:0]),
    .pc(pc),
    .imm(imm),
    .alu_result(alu_result),
    .branch_taken(branch_taken),
    .next_pc(next_pc),
    .misalign(misalign)
  );
  always_comb begin
    ld_st = instr[6:0] == OP_LOAD || instr[6:0] == OP_STORE;
    imem_req = state == S_FETCH;
    imem_addr = pc;
    pc_plus4 = pc + XLEN'(4);
    instr_valid = state == S_EXEC || state == S_WAIT_MEM;
    halted = state == S_HALT;
    commit = 1'b0;
    state_nxt = state;
    case (state)
      S_IDLE:     state_nxt = S_FETCH;
      S_FETCH:    state_nxt = imem_ack ? S_EXEC : S_FETCH;
      S_EXEC:     if (instr[6:0] == OP_SYSTEM) state_nxt = S_HALT;
                  else if (ld_st && dmem_busy) state_nxt = S_WAIT_MEM;
                  else commit = 1'b1;
      S_WAIT_MEM: commit = !dmem_busy;
      default:    state_nxt = S_HALT;
    endcase
    if (commit) state_nxt = misalign ? S_HALT : S_FETCH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc <= RESET_VEC;
      instr <= '0;
      misaligned <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && imem_ack) instr <= imem_rdata;
      if (commit && !misalign) pc <= next_pc;
      if (commit && misalign) misaligned <= 1'b1;
    end
  end
`ifdef PC_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + 64'd1;
      if (commit && !misalign) instret_cnt <= instret_cnt + 64'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus with an instruction-level reference model checked every cycle plus literal expectations
module tb_pc_sequencer;
  localparam logic [31:0] RV = 32'h0;
  localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_WAIT = 3, M_HALT = 4;
  logic clk = 0, rst = 1, imem_ack = 0, dmem_busy = 0, branch_taken = 0;
  logic [31:0] imem_rdata = 0, alu_result = 0, imm = 0;
  logic imem_req, instr_valid, commit, halted, misaligned;
  logic [31:0] imem_addr, pc, pc_plus4, instr;
`ifdef PC_SEQ_PERF_CNT_EN
  logic [63:0] cycle_cnt, instret_cnt;
`endif
  pc_sequencer #(.XLEN(32), .RESET_VEC(RV)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_busy(dmem_busy), .branch_taken(branch_taken), .alu_result(alu_result), .imm(imm),
    .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .instr_valid(instr_valid),
    .commit(commit), .halted(halted), .misaligned(misaligned)
`ifdef PC_SEQ_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );
  always #5 clk = ~clk;
  int ph = M_IDLE;
  logic [31:0] m_pc = RV, m_instr = 0, tgt;
  bit m_mis = 0;
  longint unsigned m_cyc = 0, m_ret = 0;
  function automatic bit m_commit();
    bit ls = m_instr[6:0] == 7'h03 || m_instr[6:0] == 7'h23;
    return (ph == M_EXEC && m_instr[6:0] != 7'h73 && !(ls && dmem_busy)) || (ph == M_WAIT && !dmem_busy);
  endfunction
  function automatic logic [31:0] m_target();
    if (m_instr[6:0] == 7'h6f) return m_pc + imm;
    if (m_instr[6:0] == 7'h63) return branch_taken ? m_pc + imm : m_pc + 4;
    if (m_instr[6:0] == 7'h67) return alu_result & 32'hFFFF_FFFE;
    return m_pc + 4;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      ph = M_IDLE; m_pc = RV; m_instr = 0; m_mis = 0; m_cyc = 0; m_ret = 0;
    end else begin
      if (ph != M_HALT) m_cyc++;
      if (m_commit()) begin
        tgt = m_target();
        if (tgt % 4 != 0) begin m_mis = 1; ph = M_HALT; end
        else begin m_pc = tgt; m_ret++; ph = M_FETCH; end
      end else if (ph == M_IDLE) ph = M_FETCH;
      else if (ph == M_FETCH && imem_ack) begin m_instr = imem_rdata; ph = M_EXEC; end
      else if (ph == M_EXEC) ph = (m_instr[6:0] == 7'h73) ? M_HALT : M_WAIT;
    end
  end
  int errors = 0, checks = 0;
  int n_commit = 0, n_valid = 0, n_cyc = 0;
  logic [31:0] q_addr[$];
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic compare();
    chk("imem_req", imem_req, ph == M_FETCH);
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("instr", instr, m_instr);
    chk("instr_valid", instr_valid, ph == M_EXEC || ph == M_WAIT);
    chk("commit", commit, m_commit());
    chk("halted", halted, ph == M_HALT);
    chk("misaligned", misaligned, m_mis);
`ifdef PC_SEQ_PERF_CNT_EN
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("instret_cnt", instret_cnt, m_ret);
`endif
    if (imem_req) q_addr.push_back(imem_addr);
    n_commit += int'(commit);
    n_valid += int'(instr_valid);
    n_cyc++;
  endtask
  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; imem_ack = 0; dmem_busy = 0;
    tick(); tick();
    rst = 0;
  endtask
  task automatic fetch_exec(logic [31:0] rd, logic tk, logic [31:0] im, logic [31:0] alu, int nbusy, int nwait);
    imem_ack = 0;
    repeat (nwait) tick();
    imem_ack = 1; imem_rdata = rd;
    tick();
    imem_rdata = 32'hDEADBEEF;
    branch_taken = tk; imm = im; alu_result = alu;
    dmem_busy = nbusy != 0;
    repeat (nbusy) tick();
    dmem_busy = 0;
    tick();
  endtask
  int s_c, s_v, s_cy;
`ifdef PC_SEQ_PERF_CNT_EN
  logic [63:0] cc;
`endif
  initial begin
    @(posedge clk); #1;
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_commit", commit, 0);
    chk("rst_halted", halted, 0);
    chk("rst_mis", misaligned, 0);
    chk("rst_instr", instr, 0);
    tick();
    s_c = n_commit; s_v = n_valid; s_cy = n_cyc; q_addr.delete();
    repeat (4) fetch_exec(32'h13, 0, 0, 0, 0, 0);
    chk("addi_pc", pc, 32'h10);
    chk("addi_nfetch", q_addr.size(), 4);
    if (q_addr.size() == 4) begin
      chk("addi_addr0", q_addr[0], 32'h0);
      chk("addi_addr1", q_addr[1], 32'h4);
      chk("addi_addr2", q_addr[2], 32'h8);
      chk("addi_addr3", q_addr[3], 32'hC);
    end
    chk("addi_commits", n_commit - s_c, 4);
    chk("addi_valid", n_valid - s_v, 4);
    chk("addi_cycles", n_cyc - s_cy, 8);
`ifdef PC_SEQ_PERF_CNT_EN
    chk("addi_cycle_cnt", cycle_cnt, 9);
    chk("addi_instret", instret_cnt, 4);
`endif
    fetch_exec(32'h63, 1, 32'hFFFF_FFF8, 0, 0, 0);
    chk("br_taken_pc", pc, 32'h8);
    do_reset(); tick();
    repeat (4) fetch_exec(32'h13, 0, 0, 0, 0, 0);
    fetch_exec(32'h63, 0, 32'hFFFF_FFF8, 0, 0, 0);
    chk("br_not_taken_pc", pc, 32'h14);
    fetch_exec(32'h6f, 0, 32'h100, 0, 0, 2);
    chk("jal_pc", pc, 32'h114);
    fetch_exec(32'h6f, 0, 32'hFFFF_FEF0, 0, 0, 0);
    chk("jal_wrap_pc", pc, 32'h4);
    s_c = n_commit; s_v = n_valid;
    fetch_exec(32'h03, 0, 0, 0, 3, 0);
    chk("load_valid", n_valid - s_v, 4);
    chk("load_commits", n_commit - s_c, 1);
    chk("load_pc", pc, 32'h8);
    fetch_exec(32'h23, 0, 0, 0, 0, 0);
    chk("store_pc", pc, 32'hC);
    s_c = n_commit;
    fetch_exec(32'h67, 0, 0, 32'h103, 0, 0);
    chk("jalr_mis_commit", n_commit - s_c, 1);
    chk("jalr_mis_flag", misaligned, 1);
    chk("jalr_mis_halt", halted, 1);
    chk("jalr_mis_req", imem_req, 0);
    chk("jalr_mis_pc", pc, 32'hC);
    repeat (3) tick();
    chk("halt_hold_pc", pc, 32'hC);
    chk("halt_hold_valid", instr_valid, 0);
    do_reset(); tick();
    fetch_exec(32'h67, 0, 0, 32'h41, 0, 0);
    chk("jalr_pc", pc, 32'h40);
    chk("jalr_no_mis", misaligned, 0);
    imem_ack = 0;
    tick(); tick();
    chk("stall_req", imem_req, 1);
    chk("stall_addr", imem_addr, 32'h40);
    rst = 1; imem_ack = 1; imem_rdata = 32'h6f;
    tick();
    chk("midrst_req", imem_req, 0);
    chk("midrst_pc", pc, RV);
    chk("midrst_instr", instr, 0);
    rst = 0; imem_ack = 0;
    tick();
    chk("refetch_req", imem_req, 1);
    chk("refetch_addr", imem_addr, RV);
    imem_ack = 1; imem_rdata = 32'h73;
    tick();
    s_c = n_commit;
    tick();
    chk("sys_halted", halted, 1);
    chk("sys_mis", misaligned, 0);
    chk("sys_pc", pc, RV);
    chk("sys_no_commit", n_commit - s_c, 0);
`ifdef PC_SEQ_PERF_CNT_EN
    cc = cycle_cnt;
    repeat (4) tick();
    chk("sys_cycle_freeze", cycle_cnt, cc);
    chk("sys_instret", instret_cnt, 0);
`endif
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
